// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: decode/issue sequencer in front of the combinational ALU.
// Takes one instruction per handshake, drives the ALU selects for a full
// cycle, captures result/carry, then issues a single register-file write.
module alu_issue_ctrl #(
    parameter int IMM_W = 16,
    parameter int RF_AW = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             instr_valid,
    output logic             instr_ready,
    input  logic [31:0]      instr,
    input  logic [31:0]      alu_result,
    input  logic             alu_carry,
    output logic             ALUipsel,
    output logic [4:0]       ALUopsel,
    output logic             alu_bsel,
    output logic [31:0]      imm_out,
    output logic             rf_we,
    output logic [RF_AW-1:0] rf_waddr,
    output logic [31:0]      rf_wdata,
    output logic             carry_flag,
    output logic             illegal,
    output logic             busy
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DECODE = 2'd1;
    localparam logic [1:0] ST_EXEC   = 2'd2;
    localparam logic [1:0] ST_WB     = 2'd3;

    logic [1:0]  state;
    logic [5:0]  opcode_q;
    logic [4:0]  rd_q;
    logic [15:0] low_q;
    logic        upd_carry;

    logic        dec_ok;
    logic        dec_ipsel;
    logic        dec_bsel;
    logic        dec_shift;
    logic        dec_carry;
    logic [4:0]  dec_opsel;
    logic [4:0]  func;
    logic [4:0]  shamt;
    logic [31:0] imm_sext;

    // rt is not needed here; the register file reads it directly
    logic        unused_rt;
    assign unused_rt = ^instr[20:16];

    assign func     = low_q[4:0];
    assign shamt    = low_q[15:11];
    assign imm_sext = {{(32-IMM_W){low_q[IMM_W-1]}}, low_q[IMM_W-1:0]};

    assign instr_ready = (state == ST_IDLE);
    assign busy        = (state != ST_IDLE);
    assign illegal     = (state == ST_DECODE) && !dec_ok;
    assign rf_we       = (state == ST_WB) && (rf_waddr != '0);

    // Opcode/func decode of the latched instruction
    always_comb begin
        dec_ok    = 1'b0;
        dec_ipsel = 1'b0;
        dec_bsel  = 1'b0;
        dec_shift = 1'b0;
        dec_carry = 1'b0;
        dec_opsel = '0;
        case (opcode_q)
            6'b000000: begin
                case (func)
                    5'b00001: begin dec_ok = 1'b1; dec_opsel = func; dec_carry = 1'b1; end
                    5'b00010: begin dec_ok = 1'b1; dec_opsel = func; dec_ipsel = 1'b1; end
                    5'b00011,
                    5'b00100,
                    5'b00101: begin dec_ok = 1'b1; dec_opsel = func; end
                    5'b01010,
                    5'b01000,
                    5'b01001: begin
                        dec_ok    = 1'b1;
                        dec_opsel = func;
                        dec_bsel  = 1'b1;
                        dec_shift = 1'b1;
                    end
                    default: ;
                endcase
            end
            6'b000001: begin
                dec_ok    = 1'b1;
                dec_opsel = 5'b00001;
                dec_bsel  = 1'b1;
                dec_carry = 1'b1;
            end
            6'b000010: begin
                dec_ok    = 1'b1;
                dec_opsel = 5'b00010;
                dec_ipsel = 1'b1;
                dec_bsel  = 1'b1;
            end
            default: ;
        endcase
    end

    // Sequencer: IDLE -> DECODE -> EXEC -> WB -> IDLE, selects cleared on leaving WB
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            opcode_q   <= '0;
            rd_q       <= '0;
            low_q      <= '0;
            upd_carry  <= 1'b0;
            ALUipsel   <= 1'b0;
            ALUopsel   <= '0;
            alu_bsel   <= 1'b0;
            imm_out    <= '0;
            rf_waddr   <= '0;
            rf_wdata   <= '0;
            carry_flag <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (instr_valid) begin
                        opcode_q <= instr[31:26];
                        rd_q     <= instr[25:21];
                        low_q    <= instr[15:0];
                        state    <= ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    if (dec_ok) begin
                        ALUipsel  <= dec_ipsel;
                        ALUopsel  <= dec_opsel;
                        alu_bsel  <= dec_bsel;
                        imm_out   <= dec_shift ? {27'b0, shamt} : imm_sext;
                        rf_waddr  <= RF_AW'(rd_q);
                        upd_carry <= dec_carry;
                        state     <= ST_EXEC;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_EXEC: begin
                    rf_wdata <= alu_result;
                    if (upd_carry) carry_flag <= alu_carry;
                    state <= ST_WB;
                end
                default: begin
                    ALUipsel <= 1'b0;
                    ALUopsel <= '0;
                    alu_bsel <= 1'b0;
                    imm_out  <= '0;
                    state    <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Scoreboard bench for alu_issue_ctrl: stimulus pushes hand-computed
// expectations, a negedge monitor pops them on each accepted instruction.
module tb_alu_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] alu_result;
    logic        alu_carry;
    logic        ALUipsel;
    logic [4:0]  ALUopsel;
    logic        alu_bsel;
    logic [31:0] imm_out;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        carry_flag;
    logic        illegal;
    logic        busy;

    alu_issue_ctrl #(.IMM_W(16), .RF_AW(5)) dut (
        .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr(instr), .alu_result(alu_result), .alu_carry(alu_carry),
        .ALUipsel(ALUipsel), .ALUopsel(ALUopsel), .alu_bsel(alu_bsel),
        .imm_out(imm_out), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .carry_flag(carry_flag), .illegal(illegal), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        ill;
        logic [4:0]  opsel;
        logic        ipsel;
        logic        bsel;
        logic [31:0] imm;
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic        cf;
        logic        gap;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc   = 0;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic exp_t mk(input logic ill, input logic [4:0] opsel, input logic ipsel,
                                input logic bsel, input logic [31:0] imm, input logic we,
                                input logic [4:0] waddr, input logic [31:0] wdata,
                                input logic cf, input logic gap);
        exp_t e;
        e.ill = ill; e.opsel = opsel; e.ipsel = ipsel; e.bsel = bsel; e.imm = imm;
        e.we = we; e.waddr = waddr; e.wdata = wdata; e.cf = cf; e.gap = gap;
        return e;
    endfunction

    // Monitor: follows each accepted instruction through DECODE/EXEC/WB
    int   ph = 0;
    int   last_acc = -100;
    exp_t cur;
    always @(negedge clk) begin
        if (rst) begin
            ph = 0;
        end else begin
            if (ph == 4) begin
                chk("ready_after", {31'b0, instr_ready}, 32'd1);
                ph = 0;
            end
            case (ph)
                0: begin
                    if (rf_we)   chk("spurious_rf_we", {31'b0, rf_we}, 32'd0);
                    if (illegal) chk("spurious_illegal", {31'b0, illegal}, 32'd0);
                    if (instr_valid && instr_ready) begin
                        if (sb.size() == 0) begin
                            chk("unexpected_accept", 32'd1, 32'd0);
                        end else begin
                            cur = sb.pop_front();
                            if (cur.gap) chk("accept_gap", cyc - last_acc, 32'd4);
                            last_acc = cyc;
                            ph = 1;
                        end
                    end
                end
                1: begin
                    chk("illegal", {31'b0, illegal}, {31'b0, cur.ill});
                    chk("busy_decode", {31'b0, busy}, 32'd1);
                    ph = cur.ill ? 4 : 2;
                end
                2: begin
                    chk("ALUopsel", {27'b0, ALUopsel}, {27'b0, cur.opsel});
                    chk("ALUipsel", {31'b0, ALUipsel}, {31'b0, cur.ipsel});
                    chk("alu_bsel", {31'b0, alu_bsel}, {31'b0, cur.bsel});
                    chk("imm_out", imm_out, cur.imm);
                    chk("rf_we_exec", {31'b0, rf_we}, 32'd0);
                    ph = 3;
                end
                3: begin
                    chk("rf_we", {31'b0, rf_we}, {31'b0, cur.we});
                    if (cur.we) begin
                        chk("rf_waddr", {27'b0, rf_waddr}, {27'b0, cur.waddr});
                        chk("rf_wdata", rf_wdata, cur.wdata);
                    end
                    chk("carry_flag", {31'b0, carry_flag}, {31'b0, cur.cf});
                    ph = 4;
                end
                default: ;
            endcase
        end
    end

    // Offer one instruction once the DUT is ready; called at posedge+1
    task automatic send(input logic [31:0] i, input logic [31:0] r, input logic c,
                        input logic hold, input exp_t e);
        int n = 0;
        while (!instr_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 20) chk("ready_timeout", 32'd0, 32'd1);
        sb.push_back(e);
        instr = i; alu_result = r; alu_carry = c; instr_valid = 1'b1;
        @(posedge clk); #1;
        if (!hold) instr_valid = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; instr_valid = 1'b0; instr = '0; alu_result = '0; alu_carry = 1'b0;
        idle_cycles(2);
        chk("rst_ready", {31'b0, instr_ready}, 32'd1);
        chk("rst_busy_we_ill", {29'b0, busy, rf_we, illegal}, 32'd0);
        chk("rst_sel", {25'b0, ALUipsel, ALUopsel, alu_bsel}, 32'd0);
        chk("rst_imm", imm_out, 32'd0);
        chk("rst_wb", {rf_wdata[26:0], rf_waddr}, 32'd0);
        chk("rst_carry", {31'b0, carry_flag}, 32'd0);
        rst = 1'b0;
        idle_cycles(1);

        // add rd=3, result 5 carry 1
        send(32'h0060_0001, 32'h0000_0005, 1'b1, 1'b0,
             mk(0, 5'b00001, 0, 0, 32'h0000_0001, 1, 5'd3, 32'h0000_0005, 1, 0));
        idle_cycles(5);

        // reset while an add is in EXEC: aborted, carry cleared, no write
        send(32'h0060_0001, 32'h0000_0009, 1'b0, 1'b0,
             mk(0, 5'b00001, 0, 0, 32'h0000_0001, 1, 5'd3, 32'h0000_0009, 0, 0));
        idle_cycles(1);
        chk("pre_rst_carry", {31'b0, carry_flag}, 32'd1);
        rst = 1'b1;
        idle_cycles(1);
        rst = 1'b0;
        chk("abort_ready", {31'b0, instr_ready}, 32'd1);
        chk("abort_carry", {31'b0, carry_flag}, 32'd0);
        for (int k = 0; k < 3; k++) begin
            chk("abort_no_we", {31'b0, rf_we}, 32'd0);
            idle_cycles(1);
        end

        // addi rd=4 imm=FFFF, carry 0
        send(32'h0481_FFFF, 32'h0000_1234, 1'b0, 1'b0,
             mk(0, 5'b00001, 0, 1, 32'hFFFF_FFFF, 1, 5'd4, 32'h0000_1234, 0, 0));
        // compi rd=5 imm=0010: carry_flag untouched
        send(32'h08A0_0010, 32'hFFFF_FFF0, 1'b1, 1'b0,
             mk(0, 5'b00010, 1, 1, 32'h0000_0010, 1, 5'd5, 32'hFFFF_FFF0, 0, 0));
        // shra rd=6 shamt=7
        send(32'h00C0_3809, 32'h0000_ABCD, 1'b1, 1'b0,
             mk(0, 5'b01001, 0, 1, 32'h0000_0007, 1, 5'd6, 32'h0000_ABCD, 0, 0));
        // illegal opcode 111111 and illegal R-type func 11111
        send(32'hFCE0_0001, 32'h0, 1'b0, 1'b0, mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        send(32'h00E0_001F, 32'h0, 1'b0, 1'b0, mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        // xor to rd=0: no write
        send(32'h0001_0004, 32'h0000_00FF, 1'b0, 1'b0,
             mk(0, 5'b00100, 0, 0, 32'h0000_0004, 0, 5'd0, 32'h0, 0, 0));

        // back-to-back with instr_valid held high
        send(32'h0020_0001, 32'hFFFF_FFFF, 1'b1, 1'b1,
             mk(0, 5'b00001, 0, 0, 32'h0000_0001, 1, 5'd1, 32'hFFFF_FFFF, 1, 0));
        send(32'h0040_0002, 32'h0000_0007, 1'b0, 1'b1,
             mk(0, 5'b00010, 1, 0, 32'h0000_0002, 1, 5'd2, 32'h0000_0007, 1, 1));
        send(32'h0100_0003, 32'h0000_000F, 1'b0, 1'b1,
             mk(0, 5'b00011, 0, 0, 32'h0000_0003, 1, 5'd8, 32'h0000_000F, 1, 1));
        send(32'h0120_0005, 32'h0000_0022, 1'b0, 1'b1,
             mk(0, 5'b00101, 0, 0, 32'h0000_0005, 1, 5'd9, 32'h0000_0022, 1, 1));
        send(32'h0140_F80A, 32'h8000_0000, 1'b0, 1'b1,
             mk(0, 5'b01010, 0, 1, 32'h0000_001F, 1, 5'd10, 32'h8000_0000, 1, 1));
        send(32'h03E0_0008, 32'h0000_0001, 1'b0, 1'b1,
             mk(0, 5'b01000, 0, 1, 32'h0000_0000, 1, 5'd31, 32'h0000_0001, 1, 1));
        send(32'h0560_7FFF, 32'h0000_8000, 1'b0, 1'b0,
             mk(0, 5'b00001, 0, 1, 32'h0000_7FFF, 1, 5'd11, 32'h0000_8000, 0, 1));

        idle_cycles(8);
        chk("scoreboard_drained", sb.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
- Multi-cycle decode/issue sequencer on the drive side of the processor's combinational ALU.
- Accepts one 32-bit instruction per handshake and decodes opcode/func into ALUipsel, ALUopsel and the B-source select.
- Waits one cycle for the ALU to settle, captures its result and carry, then issues a single-cycle register-file write.
- Sits between instruction fetch and the register file/ALU pair.

Parameters:
- IMM_W, 16, width of the I-type immediate field; sign-extended to 32 bits.
- RF_AW, 5, register-file address width.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- instr_valid  input  1  instruction offered
- instr_ready  output  1  block can accept an instruction (high only in IDLE)
- instr  input  32  [31:26] opcode, [25:21] rd, [20:16] rt, [15:11] shamt, [4:0] func, [15:0] imm
- alu_result  input  32  combinational ALU result
- alu_carry  input  1  combinational ALU carry-out
- ALUipsel  output  1  ALU input select (1: A=1, B=~B)
- ALUopsel  output  5  ALU operation select
- alu_bsel  output  1  0: B=register rt, 1: B=imm_out
- imm_out  output  32  sign-extended immediate, or zero-extended shamt for shifts
- rf_we  output  1  register-file write strobe, one cycle wide
- rf_waddr  output  RF_AW  write address (rd)
- rf_wdata  output  32  write data
- carry_flag  output  1  sticky carry from the last add/addi
- illegal  output  1  one-cycle pulse on an undecodable instruction
- busy  output  1  high in any state other than IDLE

Behaviour:
- Reset: state=IDLE. All outputs 0 except instr_ready=1, including carry_flag. Reset in any state aborts the instruction; no rf_we is issued for it.
- FSM states: IDLE -> DECODE -> EXEC -> WB -> IDLE.
- IDLE: instr_ready=1. When instr_valid&&instr_ready, latch instr and go to DECODE. If instr_valid is low, stay in IDLE.
- DECODE: register ALUipsel, ALUopsel, alu_bsel, imm_out and rd.
  - Undecodable instruction: pulse illegal for this cycle, go to IDLE, no write.
- EXEC: control outputs held stable for the full cycle. alu_result and alu_carry are captured at the end of the cycle.
- WB: rf_we=1 for exactly one cycle, with rf_wdata and rf_waddr set. rf_we is suppressed when rd=0. Next state is IDLE.
- Latency: 4 cycles from accept to next instr_ready. instr is ignored outside IDLE.
- R-type decode (opcode 000000):
  - func 00001 add -> ALUopsel 00001, updates carry_flag in WB.
  - func 00010 comp -> ALUopsel 00010, ALUipsel=1.
  - func 00011 and -> ALUopsel 00011.
  - func 00100 xor -> ALUopsel 00100.
  - func 00101 diff -> ALUopsel 00101.
  - func 01010 shll -> ALUopsel 01010.
  - func 01000 shrl -> ALUopsel 01000.
  - func 01001 shra -> ALUopsel 01001.
  - Shifts: alu_bsel=1, imm_out={27'b0, shamt}.
  - Any other func is illegal.
- I-type decode:
  - Opcode 000001 addi -> ALUopsel 00001, alu_bsel=1, updates carry_flag.
  - Opcode 000010 compi -> ALUopsel 00010, ALUipsel=1, alu_bsel=1.
  - Any other opcode is illegal.
- Instructions other than add/addi leave carry_flag unchanged.
- ALUipsel is 0 for every op except comp/compi.
- In IDLE, ALUopsel=00000 (pass-through) and ALUipsel=0.

Test Plan:
- Reset mid-EXEC on add: assert rst for 1 cycle -> next cycle IDLE, instr_ready=1, rf_we never pulses, carry_flag=0.
- add rd=3: instr=0x00600001 accepted at cycle 0, tie alu_result=0x0000_0005, alu_carry=1 -> ALUopsel=00001 in EXEC. At cycle 3: rf_we=1, rf_waddr=3, rf_wdata=5, carry_flag=1. instr_ready=1 again at cycle 4.
- addi imm=0xFFFF: -> imm_out=0xFFFF_FFFF, alu_bsel=1, ALUipsel=0.
- compi: -> ALUipsel=1, ALUopsel=00010.
- shra shamt=7: -> ALUopsel=01001, imm_out=0x0000_0007, alu_bsel=1.
- Illegal opcode 111111: -> illegal high for 1 cycle in DECODE, no rf_we, return to IDLE after 2 cycles.
- Write to rd=0 (xor): -> rf_we stays 0 in WB.
- instr_valid held high continuously with back-to-back instructions: -> each accepted exactly 4 cycles apart, no instruction dropped or duplicated.
